mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Data-memory stage fed directly by EX: takes ALUresult as effective address and
//   regReadData2 as store data, and performs one load/store per start pulse over a
//   req/ack data-memory bus. Handles byte lanes and load sign/zero extension, and
//   stalls the core (busy) until the access completes. Result goes to register write-back.
// PARAMETERS
//   WORD_BITWIDTH   32   data/address width (byte-lane logic fixed at 4 lanes)
//   TIMEOUT_CYCLES  255  max cycles in REQ without ack before abort (1..255)
// PORTS
//   clk           in   1   clock, rising edge
//   rst_n         in   1   asynchronous, active-low reset
//   start         in   1   1-cycle pulse: EX result valid, access requested
//   MemRead       in   1   load
//   MemWrite      in   1   store
//   funct3        in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUresult     in   32  effective byte address
//   regReadData2  in   32  store data, right-justified
//   busy          out  1   stall: high from cycle after start through DONE
//   done          out  1   1-cycle completion pulse
//   err           out  1   1-cycle pulse with done on abort/illegal access
//   readData      out  32  extended load data; holds until the next load completes
//   dmem_req      out  1   bus request; held until ack
//   dmem_we       out  1   1 = write
//   dmem_addr     out  32  word-aligned address ({ALUresult[31:2],2'b00})
//   dmem_wdata    out  32  lane-replicated store data
//   dmem_be       out  4   byte enables
//   dmem_ack      in   1   bus completion; rdata valid in the same cycle
//   dmem_rdata    in   32  read word
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0, including readData. Reset mid-access aborts:
//     dmem_req drops immediately, no done/err pulse.
//   FSM IDLE->REQ->DONE->IDLE. start is sampled only in IDLE; ignored otherwise.
//   IDLE, start=1:
//     MemRead&MemWrite, or funct3 illegal for the op (load: 011/110/111;
//       store: not 000/001/010) -> DONE with err.
//     Neither MemRead nor MemWrite -> DONE, no bus activity.
//     Otherwise -> latch addr/data/ctrl, go to REQ.
//   REQ: dmem_req=1; addr/we/be/wdata stable. Ack sampled at the clock edge.
//     Ack in the first REQ cycle is legal.
//     On ack: capture load data, go to DONE.
//     Cycle counter reaches TIMEOUT_CYCLES without ack: drop req, go to DONE with err.
//   DONE: done=1 for one cycle, then IDLE. Minimum latency: start at edge k,
//     req during k+1, done during k+2.
//   Store lanes:
//     SB: be = 4'b0001<<a[1:0], wdata = {4{d[7:0]}}
//     SH: be = a[1] ? 4'b1100 : 4'b0011, wdata = {2{d[15:0]}}
//     SW: be = 4'b1111
//   Load: select the addressed byte/half from rdata, then sign-extend (B,H) or
//     zero-extend (BU,HU). On err, readData is unchanged.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined:
//     halfword with a[0]=1, or word with a[1:0]!=0 -> no bus request;
//     DONE with err the cycle after IDLE.
//   Not defined: the offending low address bits are ignored. H uses a[1] only;
//     W uses the aligned word. The access proceeds normally.
// STRUCTURE
//   Package mem_pkg: funct3 size codes, FSM state encoding, lane/width localparams.
//   Sub-module load_extend: combinational (rdata, a[1:0], funct3) -> readData value.
// TESTING
//   1. SW a=0x100 d=0xDEADBEEF, ack 2nd REQ cycle:
//      be=1111, addr=0x100, wdata=0xDEADBEEF; done at k+3; busy k+1..k+3.
//   2. LB a=0x103, rdata=0x80000000 -> readData=0xFFFFFF80;
//      LBU same -> 0x00000080.
//   3. SH a=0x102 d=0x00001234 -> be=1100, wdata=0x12341234;
//      LH a=0x102, rdata=0x8001xxxx -> 0xFFFF8001.
//   4. No ack: req held exactly TIMEOUT_CYCLES cycles, then done+err;
//      readData unchanged.
//   5. rst_n low during REQ -> dmem_req=0 immediately; no done; next start works.
//   6. LW a=0x101: with MISALIGN_TRAP_EN -> no req, done+err at k+1;
//      without -> addr=0x100, normal load.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access unit: funct3 size codes, FSM states, lane count.
package mem_pkg;

    localparam int unsigned NumLanes = 4;

    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3BU = 3'b100;
    localparam logic [2:0] F3HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return f3 inside {F3B, F3H, F3W};
        end
        return f3 inside {F3B, F3H, F3W, F3BU, F3HU};
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: selects the addressed byte/half of a read word and extends it.
module load_extend
    import mem_pkg::*;
#(
    parameter int unsigned WORD_BITWIDTH = 32
) (
    input  logic [WORD_BITWIDTH-1:0] rdata,
    input  logic [1:0]               addr_lo,
    input  logic [2:0]               funct3,
    output logic [WORD_BITWIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        // Halfwords use a[1] only; a[0] is ignored when misalignment is not trapped.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3B:     data = {{(WORD_BITWIDTH-8){byte_sel[7]}}, byte_sel};
            F3BU:    data = {{(WORD_BITWIDTH-8){1'b0}}, byte_sel};
            F3H:     data = {{(WORD_BITWIDTH-16){half_sel[15]}}, half_sel};
            F3HU:    data = {{(WORD_BITWIDTH-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory stage: one load/store per start pulse over a req/ack bus, with lane steering.
// Define MISALIGN_TRAP_EN to abort misaligned half/word accesses with err instead of aligning.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned WORD_BITWIDTH  = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [2:0]               funct3,
    input  logic [WORD_BITWIDTH-1:0] ALUresult,
    input  logic [WORD_BITWIDTH-1:0] regReadData2,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [WORD_BITWIDTH-1:0] readData,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [WORD_BITWIDTH-1:0] dmem_addr,
    output logic [WORD_BITWIDTH-1:0] dmem_wdata,
    output logic [NumLanes-1:0]      dmem_be,
    input  logic                     dmem_ack,
    input  logic [WORD_BITWIDTH-1:0] dmem_rdata
);

    state_e                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     busy_q, busy_d, done_q, done_d, err_q, err_d, req_q, req_d;
    logic                     we_q, we_d;
    logic [WORD_BITWIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, read_data_q, read_data_d;
    logic [NumLanes-1:0]      be_q, be_d;
    logic [2:0]               f3_q, f3_d;
    logic [1:0]               alo_q, alo_d;
    logic [WORD_BITWIDTH-1:0] load_val;
    logic                     illegal, misalign;

    load_extend #(
        .WORD_BITWIDTH(WORD_BITWIDTH)
    ) u_load_extend (
        .rdata  (dmem_rdata),
        .addr_lo(alo_q),
        .funct3 (f3_q),
        .data   (load_val)
    );

`ifdef MISALIGN_TRAP_EN
    assign misalign = f3_misaligned(funct3, ALUresult[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign illegal = (MemRead && MemWrite) ||
                     ((MemRead || MemWrite) && (!f3_legal(MemWrite, funct3) || misalign));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        f3_d        = f3_q;
        alo_d       = alo_q;
        read_data_d = read_data_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StDone;
                    if (illegal) begin
                        err_d = 1'b1;
                    end else if (MemRead || MemWrite) begin
                        state_d = StReq;
                        cnt_d   = 8'd0;
                        we_d    = MemWrite;
                        addr_d  = {ALUresult[WORD_BITWIDTH-1:2], 2'b00};
                        f3_d    = funct3;
                        alo_d   = ALUresult[1:0];
                        case (funct3[1:0])
                            2'b00: begin
                                be_d    = 4'b0001 << ALUresult[1:0];
                                wdata_d = {4{regReadData2[7:0]}};
                            end
                            2'b01: begin
                                be_d    = ALUresult[1] ? 4'b1100 : 4'b0011;
                                wdata_d = {2{regReadData2[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = regReadData2;
                            end
                        endcase
                    end
                end
            end
            StReq: begin
                if (dmem_ack) begin
                    state_d = StDone;
                    if (!we_q) begin
                        read_data_d = load_val;
                    end
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
        req_d  = (state_d == StReq);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            f3_q        <= 3'b000;
            alo_q       <= 2'b00;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            f3_q        <= f3_d;
            alo_q       <= alo_d;
            read_data_q <= read_data_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign readData   = read_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random accesses vs. a reference model.
module tb_mem_access_unit;

    localparam int TIMEOUT = 255;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUresult;
    logic [31:0] regReadData2;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] readData;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int          n_cmp;
    int          n_bad;
    logic [31:0] exp_rd;

    mem_access_unit #(
        .WORD_BITWIDTH (32),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .funct3      (funct3),
        .ALUresult   (ALUresult),
        .regReadData2(regReadData2),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .readData    (readData),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ref_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Byte offset of the accessed item inside the word, low address bits ignored as needed.
    function automatic int ref_off(input logic [31:0] a, input int sz);
        return (int'(a % 4) / sz) * sz;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] a,
                                             input logic [2:0] f3);
        int          sz;
        logic [31:0] v;
        sz = ref_size(f3);
        if (sz == 4) return rdata;
        v = (rdata >> (8 * ref_off(a, sz))) & ((32'd1 << (8 * sz)) - 32'd1);
        if (!f3[2] && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic [31:0] a, input logic [2:0] f3);
        int sz;
        sz = ref_size(f3);
        return ((32'd1 << sz) - 32'd1) << ref_off(a, sz);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [2:0] f3);
        int sz;
        sz = ref_size(f3);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // ack_at: REQ cycle index (0 = first) in which ack is given; -1 = never.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                              input int ack_at, input logic [31:0] rdata);
        int   sz;
        int   n;
        int   done_at;
        logic illegal;
        logic trap;
        logic bus;
        logic exp_err;
        sz      = ref_size(f3);
        illegal = (rd && wr) || (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
                  (wr && !(f3 inside {3'd0, 3'd1, 3'd2}));
`ifdef MISALIGN_TRAP_EN
        trap    = (rd || wr) && !illegal && ((a % sz) != 0);
`else
        trap    = 1'b0;
`endif
        bus     = (rd || wr) && !illegal && !trap;
        exp_err = illegal || trap || (bus && ack_at < 0);
        done_at = !bus ? 1 : (ack_at < 0 ? TIMEOUT + 1 : ack_at + 2);

        @(negedge clk);
        start        = 1'b1;
        MemRead      = rd;
        MemWrite     = wr;
        funct3       = f3;
        ALUresult    = a;
        regReadData2 = d;
        @(negedge clk);
        start        = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        ALUresult    = $urandom;
        regReadData2 = $urandom;
        n = 1;
        if (bus) begin
            chk({tag, " addr"}, dmem_addr, a & 32'hFFFF_FFFC);
            chk({tag, " we"}, 32'(dmem_we), 32'(wr));
            if (wr) begin
                chk({tag, " be"}, 32'(dmem_be), ref_be(a, f3));
                chk({tag, " wdata"}, dmem_wdata, ref_wdata(d, f3));
            end
            while (n < done_at) begin
                chk({tag, " req"}, 32'(dmem_req), 32'd1);
                chk({tag, " busy"}, 32'(busy), 32'd1);
                chk({tag, " early_done"}, 32'(done), 32'd0);
                if (n == ack_at + 1) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
                @(negedge clk);
                dmem_ack   = 1'b0;
                dmem_rdata = $urandom;
                n++;
            end
        end
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " err"}, 32'(err), 32'(exp_err));
        chk({tag, " busy_done"}, 32'(busy), 32'd1);
        chk({tag, " req_done"}, 32'(dmem_req), 32'd0);
        if (bus && rd && ack_at >= 0) exp_rd = ref_load(rdata, a, f3);
        chk({tag, " readData"}, readData, exp_rd);
        @(negedge clk);
        chk({tag, " done_clr"}, 32'(done), 32'd0);
        chk({tag, " busy_clr"}, 32'(busy), 32'd0);
        chk({tag, " err_clr"}, 32'(err), 32'd0);
    endtask

    initial begin
        int          op;
        logic        rd;
        logic        wr;
        n_cmp        = 0;
        n_bad        = 0;
        exp_rd       = 32'd0;
        rst_n        = 1'b0;
        start        = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        funct3       = 3'b000;
        ALUresult    = 32'd0;
        regReadData2 = 32'd0;
        dmem_ack     = 1'b0;
        dmem_rdata   = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst req", 32'(dmem_req), 32'd0);
        chk("rst we", 32'(dmem_we), 32'd0);
        chk("rst addr", dmem_addr, 32'd0);
        chk("rst wdata", dmem_wdata, 32'd0);
        chk("rst be", 32'(dmem_be), 32'd0);
        chk("rst readData", readData, 32'd0);
        rst_n = 1'b1;

        run_access("sw", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1, 32'd0);
        run_access("lb", 1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 0, 32'h8000_0000);
        run_access("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 0, 32'h8000_0000);
        run_access("sh", 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_1234, 0, 32'd0);
        run_access("lh", 1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 2, 32'h8001_5A5A);
        run_access("sb", 1'b0, 1'b1, 3'b000, 32'h201, 32'h0000_00A7, 0, 32'd0);
        run_access("lw", 1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 0, 32'h1357_9BDF);
        run_access("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h300, 32'd0, -1, 32'd0);

        // Reset in the middle of a bus request.
        @(negedge clk);
        start     = 1'b1;
        MemWrite  = 1'b1;
        funct3    = 3'b010;
        ALUresult = 32'h400;
        @(negedge clk);
        start    = 1'b0;
        MemWrite = 1'b0;
        chk("mid_rst req_before", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst req_drop", 32'(dmem_req), 32'd0);
        chk("mid_rst busy_drop", 32'(busy), 32'd0);
        exp_rd = 32'd0;
        chk("mid_rst readData", readData, exp_rd);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst no_done", 32'(done), 32'd0);
            chk("mid_rst no_err", 32'(err), 32'd0);
        end
        run_access("after_rst", 1'b1, 1'b0, 3'b101, 32'h402, 32'd0, 0, 32'hF00D_8ACE);

        run_access("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 0, 32'hCAFE_F00D);
        run_access("lh_mis", 1'b1, 1'b0, 3'b001, 32'h103, 32'd0, 1, 32'h9ABC_1234);
        run_access("rw_both", 1'b1, 1'b1, 3'b010, 32'h100, 32'h1, 0, 32'd0);
        run_access("ld_f3_011", 1'b1, 1'b0, 3'b011, 32'h100, 32'd0, 0, 32'h5555_AAAA);
        run_access("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h100, 32'h77, 0, 32'd0);
        run_access("nop", 1'b0, 1'b0, 3'b010, 32'h100, 32'd0, 0, 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(7, 0));
            rd = (op <= 2) || (op == 6);
            wr = (op >= 3 && op <= 5) || (op == 6);
            run_access($sformatf("rnd%0d", i), rd, wr, 3'($urandom_range(7, 0)), $urandom,
                       $urandom, int'($urandom_range(3, 0)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
